// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read/1-write register file with a per-register busy scoreboard.
// Optional write-through forwarding on both read ports: define REGFILE_BYPASS_EN.
module regfile_2r1w_param #(
   parameter int unsigned            DATA_W    = 4,
   parameter int unsigned            ADDR_W    = 2,
   parameter logic [DATA_W-1:0]      RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_enable,
   input  logic [ADDR_W-1:0] D_address,
   input  logic [DATA_W-1:0] bus_D,
   input  logic [ADDR_W-1:0] A_select,
   input  logic [ADDR_W-1:0] B_select,
   output logic [DATA_W-1:0] bus_A,
   output logic [DATA_W-1:0] bus_B,
   input  logic              reserve_en,
   input  logic [ADDR_W-1:0] reserve_addr,
   output logic              busy_A,
   output logic              busy_B,
   output logic              busy_any
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= RESET_VAL;
         end
         busy <= '0;
      end else begin
         if (load_enable) begin
            regs[D_address] <= bus_D;
         end
         // A reservation wins over a same-cycle write: the write retires the old producer.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (reserve_en && reserve_addr == ADDR_W'(i)) begin
               busy[i] <= 1'b1;
            end else if (load_enable && D_address == ADDR_W'(i)) begin
               busy[i] <= 1'b0;
            end
         end
      end
   end

   assign busy_any = |busy;

`ifdef REGFILE_BYPASS_EN
   logic fwd_a;
   logic fwd_b;

   // Forwarding is suppressed while reset is held so outputs show RESET_VAL.
   assign fwd_a = rst_n && load_enable && (D_address == A_select);
   assign fwd_b = rst_n && load_enable && (D_address == B_select);

   always_comb begin
      bus_A  = regs[A_select];
      bus_B  = regs[B_select];
      busy_A = busy[A_select];
      busy_B = busy[B_select];
      if (fwd_a) begin
         bus_A  = bus_D;
         busy_A = reserve_en && (reserve_addr == A_select);
      end
      if (fwd_b) begin
         bus_B  = bus_D;
         busy_B = reserve_en && (reserve_addr == B_select);
      end
   end
`else
   always_comb begin
      bus_A  = regs[A_select];
      bus_B  = regs[B_select];
      busy_A = busy[A_select];
      busy_B = busy[B_select];
   end
`endif

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Bench for regfile_2r1w_param: directed scenarios plus randomized traffic against an array model.
module tb_regfile_2r1w_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       load_enable;
   logic [1:0] D_address;
   logic [3:0] bus_D;
   logic [1:0] A_select;
   logic [1:0] B_select;
   logic [3:0] bus_A;
   logic [3:0] bus_B;
   logic       reserve_en;
   logic [1:0] reserve_addr;
   logic       busy_A;
   logic       busy_B;
   logic       busy_any;

   logic       s_load_enable;
   logic [2:0] s_D_address;
   logic [7:0] s_bus_D;
   logic [2:0] s_A_select;
   logic [2:0] s_B_select;
   logic [7:0] s_bus_A;
   logic [7:0] s_bus_B;
   logic       s_reserve_en;
   logic [2:0] s_reserve_addr;
   logic       s_busy_A;
   logic       s_busy_B;
   logic       s_busy_any;

   int compared   = 0;
   int mismatched = 0;
   bit checking   = 1'b0;

   always #5 clk = ~clk;

   regfile_2r1w_param dut (
      .clk(clk), .rst_n(rst_n), .load_enable(load_enable), .D_address(D_address),
      .bus_D(bus_D), .A_select(A_select), .B_select(B_select), .bus_A(bus_A),
      .bus_B(bus_B), .reserve_en(reserve_en), .reserve_addr(reserve_addr),
      .busy_A(busy_A), .busy_B(busy_B), .busy_any(busy_any)
   );

   regfile_2r1w_param #(.DATA_W(8), .ADDR_W(3), .RESET_VAL(8'h3C)) dut_wide (
      .clk(clk), .rst_n(rst_n), .load_enable(s_load_enable), .D_address(s_D_address),
      .bus_D(s_bus_D), .A_select(s_A_select), .B_select(s_B_select), .bus_A(s_bus_A),
      .bus_B(s_bus_B), .reserve_en(s_reserve_en), .reserve_addr(s_reserve_addr),
      .busy_A(s_busy_A), .busy_B(s_busy_B), .busy_any(s_busy_any)
   );

   // Reference model: plain arrays, updated write-first then reservation.
   int m_val  [4];
   bit m_busy [4];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_val[i]  = 0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (load_enable === 1'b1) begin
            m_val[D_address]  = int'(bus_D);
            m_busy[D_address] = 1'b0;
         end
         if (reserve_en === 1'b1) m_busy[reserve_addr] = 1'b1;
      end
   end

   function automatic int exp_data(input int sel);
`ifdef REGFILE_BYPASS_EN
      if (rst_n && load_enable && int'(D_address) == sel) return int'(bus_D);
`endif
      return m_val[sel];
   endfunction

   function automatic int exp_busy(input int sel);
`ifdef REGFILE_BYPASS_EN
      if (rst_n && load_enable && int'(D_address) == sel)
         return (reserve_en && int'(reserve_addr) == sel) ? 1 : 0;
`endif
      return m_busy[sel] ? 1 : 0;
   endfunction

   function automatic int exp_any();
      for (int i = 0; i < 4; i++) if (m_busy[i]) return 1;
      return 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("cyc bus_A",    32'(bus_A),    32'(exp_data(int'(A_select))));
         chk("cyc bus_B",    32'(bus_B),    32'(exp_data(int'(B_select))));
         chk("cyc busy_A",   32'(busy_A),   32'(exp_busy(int'(A_select))));
         chk("cyc busy_B",   32'(busy_B),   32'(exp_busy(int'(B_select))));
         chk("cyc busy_any", 32'(busy_any), 32'(exp_any()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input int data);
      load_enable = 1'b1;
      D_address   = 2'(addr);
      bus_D       = 4'(data);
      tick();
      load_enable = 1'b0;
   endtask

   initial begin
      load_enable = 1'b0; D_address = '0; bus_D = '0; A_select = '0; B_select = '0;
      reserve_en = 1'b0; reserve_addr = '0;
      s_load_enable = 1'b0; s_D_address = '0; s_bus_D = '0; s_A_select = '0;
      s_B_select = '0; s_reserve_en = 1'b0; s_reserve_addr = '0;
      #1 rst_n = 1'b0;
      #11 rst_n = 1'b1;
      checking = 1'b1;
      tick();

      chk("reset bus_A", 32'(bus_A), 32'h0);
      chk("reset wide bus_A", 32'(s_bus_A), 32'h3C);

      // Write all, read crossed on both ports
      for (int i = 0; i < 4; i++) wr(i, i + 5);
      for (int i = 0; i < 4; i++) begin
         A_select = 2'(i);
         B_select = 2'(3 - i);
         #1;
         chk("wr/rd bus_A", 32'(bus_A), 32'(i + 5));
         chk("wr/rd bus_B", 32'(bus_B), 32'(8 - i));
      end
      load_enable = 1'b0; D_address = 2'd2; bus_D = 4'hF; A_select = 2'd2;
      tick();
      chk("no-load hold", 32'(bus_A), 32'h7);

      // Async reset between edges with a busy register outstanding
      reserve_en = 1'b1; reserve_addr = 2'd0;
      tick();
      reserve_en = 1'b0;
      chk("pre-reset busy_any", 32'(busy_any), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async reset bus_A", 32'(bus_A), 32'h0);
      chk("async reset bus_B", 32'(bus_B), 32'h0);
      chk("async reset busy_any", 32'(busy_any), 32'h0);
      #1 rst_n = 1'b1;
      tick();

      // Scoreboard reserve then retire
      A_select = 2'd2; reserve_en = 1'b1; reserve_addr = 2'd2;
      tick();
      reserve_en = 1'b0;
      chk("sb busy_A", 32'(busy_A), 32'h1);
      chk("sb busy_any", 32'(busy_any), 32'h1);
      wr(2, 4'hA);
      chk("sb retire busy_A", 32'(busy_A), 32'h0);
      chk("sb retire busy_any", 32'(busy_any), 32'h0);
      chk("sb retire bus_A", 32'(bus_A), 32'hA);

      // Same-edge reserve and write on a busy register
      reserve_en = 1'b1; reserve_addr = 2'd1;
      tick();
      load_enable = 1'b1; D_address = 2'd1; bus_D = 4'h7;
      tick();
      load_enable = 1'b0; reserve_en = 1'b0; A_select = 2'd1;
      #1;
      chk("collide bus_A", 32'(bus_A), 32'h7);
      chk("collide busy_A", 32'(busy_A), 32'h1);
      wr(1, 4'h7);
      chk("collide cleared", 32'(busy_A), 32'h0);

      // Forwarding window before the write edge
      wr(3, 4'h9);
      load_enable = 1'b1; D_address = 2'd3; A_select = 2'd3; bus_D = 4'hC;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass pre-edge", 32'(bus_A), 32'hC);
`else
      chk("no-bypass pre-edge", 32'(bus_A), 32'h9);
`endif
      tick();
      load_enable = 1'b0;
      chk("post-edge bus_A", 32'(bus_A), 32'hC);

      // Wide instance: 8-bit data, 8 registers
      s_load_enable = 1'b1; s_D_address = 3'd7; s_bus_D = 8'hA5;
      tick();
      s_D_address = 3'd0; s_bus_D = 8'h11;
      tick();
      s_load_enable = 1'b0; s_A_select = 3'd7; s_B_select = 3'd7;
      #1;
      chk("wide bus_A", 32'(s_bus_A), 32'hA5);
      chk("wide bus_B", 32'(s_bus_B), 32'hA5);
      s_B_select = 3'd0;
      #1;
      chk("wide reg0", 32'(s_bus_B), 32'h11);
      s_A_select = 3'd6;
      #1;
      chk("wide untouched", 32'(s_bus_A), 32'h3C);
      s_reserve_en = 1'b1; s_reserve_addr = 3'd6;
      tick();
      s_reserve_en = 1'b0;
      chk("wide busy_A", 32'(s_busy_A), 32'h1);
      chk("wide busy_B", 32'(s_busy_B), 32'h0);

      // Randomized traffic, checked every negedge against the model
      for (int n = 0; n < 600; n++) begin
         load_enable  = 1'($urandom_range(0, 1));
         D_address    = 2'($urandom);
         bus_D        = 4'($urandom);
         A_select     = 2'($urandom);
         B_select     = ($urandom_range(0, 3) == 0) ? A_select : 2'($urandom);
         reserve_en   = ($urandom_range(0, 2) == 0);
         reserve_addr = ($urandom_range(0, 3) == 0) ? D_address : 2'($urandom);
         if ($urandom_range(0, 60) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         tick();
      end

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
